// File: rtl/decoder_scan_sequencer.sv
// Round-robin scan driver for a 2x4 decoder: sel/en with a blanking gap between slots.
// Optional frame counter outputs are built when SCAN_FRAME_CNT_EN is defined.
module decoder_scan_sequencer #(
    parameter int SLOT_CYCLES  = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       slot_start,
    output logic       busy
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic       frame_pulse,
    output logic [7:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic             slot_start_q, slot_start_d;
    logic             busy_q, busy_d;
    logic [1:0]       lowest_idx, next_idx, cand;
    logic             act_last, blank_last, slot_done;

    assign act_last   = (cnt_q == SLOT_LAST);
    assign blank_last = (cnt_q == BLANK_LAST);
    assign slot_done  = (state_q == ACTIVE) && act_last;

    // Slot search: iterate from the far end so the nearest candidate wins.
    // Offset 4 aliases back to sel_q, giving the single-slot case last priority.
    always_comb begin
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (mask[i]) lowest_idx = 2'(i);
        next_idx = sel_q;
        cand     = sel_q;
        for (int off = 4; off >= 1; off--) begin
            cand = sel_q + off[1:0];
            if (mask[cand]) next_idx = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            en_q         <= 1'b0;
            slot_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            slot_start_q <= slot_start_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && (mask != 4'd0)) begin
                    state_d = (BLANK_CYCLES > 0) ? BLANK : ACTIVE;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (blank_last) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (act_last) begin
                    cnt_d = '0;
                    if (mask == 4'd0)          state_d = IDLE;
                    else if (BLANK_CYCLES > 0) state_d = BLANK;
                    else                       state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_comb begin
        en_d         = (state_d == ACTIVE);
        busy_d       = (state_d != IDLE);
        slot_start_d = (state_d == ACTIVE) && ((state_q != ACTIVE) || slot_done);
        sel_d        = sel_q;
        if ((state_q == IDLE) && (state_d != IDLE))
            sel_d = lowest_idx;
        else if (slot_done && (state_d != IDLE))
            sel_d = next_idx;
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign slot_start = slot_start_q;
    assign busy       = busy_q;

`ifdef SCAN_FRAME_CNT_EN
    logic       frame_pulse_q, frame_pulse_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_pulse_d = slot_done && (state_d != IDLE) && (next_idx <= sel_q);
        frame_cnt_d   = frame_cnt_q + {7'd0, frame_pulse_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_pulse_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            frame_pulse_q <= frame_pulse_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_pulse = frame_pulse_q;
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed vector bench for decoder_scan_sequencer (default and zero-blank builds).
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [1:0] sel;
    logic       en, slot_start, busy;
    logic       start_b = 1'b0, stop_b = 1'b0;
    logic [3:0] mask_b = 4'd0;
    logic [1:0] sel_b;
    logic       en_b, slot_start_b, busy_b;
`ifdef SCAN_FRAME_CNT_EN
    logic       frame_pulse, frame_pulse_b;
    logic [7:0] frame_cnt, frame_cnt_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
        .sel(sel), .en(en), .slot_start(slot_start), .busy(busy)
`ifdef SCAN_FRAME_CNT_EN
        , .frame_pulse(frame_pulse), .frame_cnt(frame_cnt)
`endif
    );

    decoder_scan_sequencer #(.SLOT_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .mask(mask_b),
        .sel(sel_b), .en(en_b), .slot_start(slot_start_b), .busy(busy_b)
`ifdef SCAN_FRAME_CNT_EN
        , .frame_pulse(frame_pulse_b), .frame_cnt(frame_cnt_b)
`endif
    );

    typedef struct {
        bit         rst;
        bit         start;
        bit         stop;
        logic [3:0] mask;
        logic [1:0] sel;
        bit         en;
        bit         ss;
        bit         busy;
        bit         fp;
        logic [7:0] fc;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit r, bit st, bit sp, logic [3:0] m, logic [1:0] s,
                                bit e, bit ss, bit b, bit fp, int fc);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.mask = m; v.sel = s;
        v.en = e; v.ss = ss; v.busy = b; v.fp = fp; v.fc = 8'(fc);
        tv.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    initial begin
        int order_full[5];
        int order_sparse[6];
        int fc;
        order_full   = '{0, 1, 2, 3, 0};
        order_sparse = '{1, 3, 1, 3, 1, 3};

        // Full scan, mask 1111, blank 1 / slot 4; start asserted mid-slot is ignored.
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4'hF, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) add(0, 0, 0, 4'hF, 2'(order_full[k]), 0, 0, 1, (k == 4), (k == 4) ? 1 : 0);
            for (int c = 0; c < 4; c++)
                add(0, (c == 1), 0, 4'hF, 2'(order_full[k]), 1, (c == 0), 1, 0, (k == 4) ? 1 : 0);
        end
        add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 4'hF, 0, 0, 0, 0, 0, 1);

        // Sparse mask 1010 after a fresh reset; wrap after each slot-3 window.
        add(1, 1, 0, 4'hA, 1, 0, 0, 1, 0, 0);
        fc = 0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++)
                add(0, 0, 0, 4'hA, 2'(order_sparse[k]), 1, (c == 0), 1, 0, fc);
            if (order_sparse[k] == 3) fc++;
            add(0, 0, 0, 4'hA, (order_sparse[k] == 3) ? 2'd1 : 2'd3, 0, 0, 1,
                (order_sparse[k] == 3), fc);
        end
        add(0, 0, 1, 4'hA, 1, 0, 0, 0, 0, 3);

        // Mask drops to zero in the second active cycle: window still completes.
        add(0, 1, 0, 4'h8, 3, 0, 0, 1, 0, 3);
        add(0, 0, 0, 4'h8, 3, 1, 1, 1, 0, 3);
        add(0, 0, 0, 4'h0, 3, 1, 0, 1, 0, 3);
        add(0, 0, 0, 4'h0, 3, 1, 0, 1, 0, 3);
        add(0, 0, 0, 4'h0, 3, 1, 0, 1, 0, 3);
        add(0, 0, 0, 4'h0, 3, 0, 0, 0, 0, 3);
        add(0, 1, 0, 4'h0, 3, 0, 0, 0, 0, 3);

        // Stop during blank: en never rises.
        add(0, 1, 0, 4'hF, 0, 0, 0, 1, 0, 3);
        add(0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 3);

        foreach (tv[i]) begin
            @(negedge clk);
            if (tv[i].rst) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            start = tv[i].start;
            stop  = tv[i].stop;
            mask  = tv[i].mask;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sel", i), sel, tv[i].sel);
            chk($sformatf("v%0d_en", i), en, tv[i].en);
            chk($sformatf("v%0d_slot_start", i), slot_start, tv[i].ss);
            chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
`ifdef SCAN_FRAME_CNT_EN
            chk($sformatf("v%0d_frame_pulse", i), frame_pulse, tv[i].fp);
            chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tv[i].fc);
`endif
        end

        // Asynchronous reset in the middle of an active window (slot 2).
        @(negedge clk);
        stop = 1'b0; start = 1'b1; mask = 4'b0100;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_en", en, 1);
        chk("pre_reset_sel", sel, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", en, 0);
        chk("async_rst_sel", sel, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ss", slot_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_busy", i), busy, 0);
            chk($sformatf("post_rst%0d_en", i), en, 0);
        end

        // Zero blank, single slot: en continuous, slot_start every 4 cycles.
        @(negedge clk);
        mask_b = 4'b0100; start_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b0_sel", sel_b, 2);
        chk("b0_en", en_b, 1);
        chk("b0_ss", slot_start_b, 1);
        chk("b0_busy", busy_b, 1);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 1; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b%0d_en", i), en_b, 1);
            chk($sformatf("b%0d_sel", i), sel_b, 2);
            chk($sformatf("b%0d_ss", i), slot_start_b, (i % 4 == 0));
        end
        @(negedge clk);
        stop_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b_stop_en", en_b, 0);
        chk("b_stop_busy", busy_b, 0);
        chk("b_stop_sel", sel_b, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 2x4 decoder stage. Generates the 2-bit select (sel) and enable (en) that the decoder turns into one-hot lines.
- Scans round-robin over the four decoder outputs, skipping masked slots.
- Each slot has a fixed active window. A blanking gap with en low separates consecutive slots, so two decoded outputs are never active in the same cycle.
- Typical use is display digit scanning and multiplexed channel select.

Parameters:
- SLOT_CYCLES, 4, cycles en is held high per slot; legal range 1..2^CNT_W-1.
- BLANK_CYCLES, 1, cycles en is held low before each slot's active window; legal range 0..2^CNT_W-1.
- CNT_W, 8, width of the internal phase counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled; starts a scan when in IDLE.
- stop  input  1  level-sampled; aborts the scan immediately; takes priority over start.
- mask  input  4  slot enable; bit i=1 means decoder output i is scanned; sampled whenever the next slot is chosen.
- sel  output  2  registered; connects to the decoder x input.
- en  output  1  registered; connects to the decoder en input.
- slot_start  output  1  registered one-cycle pulse on the first en=1 cycle of every slot.
- busy  output  1  registered; 1 in every state except IDLE.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, sel=0, en=0, slot_start=0, busy=0, counter=0.
  - Takes effect immediately with no clock needed, including mid-slot.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - en=0; sel holds its last value.
  - If start=1, stop=0 and mask!=0 at edge k: sel <= index of the lowest set mask bit, busy <= 1.
  - Then state <= BLANK if BLANK_CYCLES>0, else ACTIVE (with slot_start=1 at edge k).
  - start with mask==0 is ignored; the block stays in IDLE.
- BLANK:
  - en=0 for exactly BLANK_CYCLES cycles; sel is already the new slot and is stable.
  - After the last blank cycle, enters ACTIVE with en=1 and slot_start=1 on the same edge.
- ACTIVE:
  - en=1 for exactly SLOT_CYCLES cycles; sel is constant.
  - At the end of the last active cycle, the next slot is the first set mask bit strictly after sel, searching circularly (3 wraps to 0).
  - If only the current bit is set, the next slot is the same slot. It is still preceded by a blank gap.
  - If mask==0 at that point: state <= IDLE, en <= 0, busy <= 0, sel holds.
  - If BLANK_CYCLES=0: en stays 1, sel changes and slot_start pulses on the same edge. There is back-to-back slot switching with no gap.
- Latency with start sampled at edge k:
  - en rises at edge k+BLANK_CYCLES.
  - Slot period is BLANK_CYCLES+SLOT_CYCLES cycles.
- Mask changes mid-slot do not cut the current slot short. They affect only the next slot choice.
- stop=1 at any edge, in any state: state <= IDLE, en <= 0, slot_start <= 0, busy <= 0, sel holds, counter <= 0.
  - stop and start in the same cycle: the block goes to or stays in IDLE.
- start while busy=1 is ignored; there is no restart.
- Counter arithmetic is unsigned CNT_W bits. It counts 0..N-1 per phase and reloads to 0 on every phase change, so it never wraps.

Optional Feature:
- Macro: SCAN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_pulse (1 bit, registered) and output frame_cnt (8 bits, registered).
  - frame_pulse=1 for one cycle on the edge where ACTIVE completes and the chosen next slot index <= the current sel. This covers wrap-around and single-slot masks.
  - frame_cnt increments on that same edge and wraps from 255 to 0.
  - Both reset to 0. stop clears frame_pulse but does not clear frame_cnt.
- Undefined: neither port exists and neither register is synthesised. All other behaviour is identical.

Test Plan:
- Reset mid-scan: defaults, mask=4'b1111, start; assert rst_n=0 mid-ACTIVE between clock edges -> en=0, sel=0, busy=0 immediately; after release the block stays IDLE.
- Full scan: defaults, mask=4'b1111, start at edge k -> sel sequence 0,1,2,3,0; each slot is en=0 for 1 cycle then en=1 for 4 cycles; slot_start every 5 cycles, first at edge k+1.
- Sparse mask: mask=4'b1010 -> sel alternates 1,3,1,3; slots 0 and 2 never have en=1; with SCAN_FRAME_CNT_EN, frame_pulse fires after each slot-3 window and frame_cnt counts 1,2,3.
- Mask to zero: mask drops to 4'b0000 at cycle 2 of an active window -> 4 en=1 cycles still complete, then en=0, busy=0, IDLE, sel held.
- Single slot, no blank: BLANK_CYCLES=0, mask=4'b0100 -> sel stays 2, en stays continuously 1, slot_start pulses every 4 cycles.
- Stop priority: in IDLE, start=1 and stop=1 together -> busy stays 0; during BLANK, stop=1 -> IDLE next edge and en never rises.
